// File: rtl/uart_n_if.sv
// Bus between the message builder (master) and the multi-byte UART transmitter (slave).
interface uart_n_if;
    logic [63:0] buffer;
    logic [3:0]  num;
    logic        trig_in;
    logic        idle;
    logic        tx;

    modport master (output buffer, output num, output trig_in, input idle, input tx);
    modport slave  (input buffer, input num, input trig_in, output idle, output tx);
endinterface

// File: rtl/uart_n.sv
// Multi-byte 8-N-1 UART transmitter: latches up to 8 bytes on trigger and sends them back-to-back.
// Define UART_N_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_n #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic     i_clk,
    input  logic     i_rst,
    uart_n_if.slave  bus
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_N_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [3:0]       r_byte_cnt;
    logic [63:0]      r_shift;
    logic             r_tx;
    logic             r_idle;

    logic [3:0]       w_num_eff;
    logic             w_bit_end;
    logic             w_start;
    logic             w_tx_next;
    logic [7:0]       w_byte;

    assign w_num_eff = (bus.num > 4'd8) ? 4'd8 : bus.num;
    assign w_bit_end = (r_bit_cnt == CNT_LAST);
    assign w_byte    = r_shift[7:0];

    assign bus.tx    = r_tx;
    assign bus.idle  = r_idle;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // TX is the registered image of the current state, so outputs trail the FSM by one cycle.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = 1'b1;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.trig_in && (w_num_eff != 4'd0)) begin
                    w_start      = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = w_byte[r_bit_idx];
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_N_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_N_PARITY_EN
            S_PARITY: begin
                w_tx_next = ^w_byte;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    w_state_next = (r_byte_cnt == 4'd1) ? S_IDLE : S_START;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx       <= 1'b1;
            r_idle     <= 1'b1;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else begin
            r_tx   <= w_tx_next;
            r_idle <= (r_state == S_IDLE);
            if (w_start) begin
                r_shift    <= bus.buffer;
                r_byte_cnt <= w_num_eff;
                r_bit_cnt  <= '0;
                r_bit_idx  <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_bit_end) begin
                    r_bit_cnt <= '0;
                    if (r_state == S_DATA) begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    // End of stop bit: retire the byte and expose the next one.
                    if (r_state == S_STOP) begin
                        r_byte_cnt <= r_byte_cnt - 4'd1;
                        r_shift    <= {8'h00, r_shift[63:8]};
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_n.sv
// Directed bench for uart_n with CLKS_PER_BIT=4; frame width follows UART_N_PARITY_EN.
module tb_uart_n;

    localparam int C = 4;
`ifdef UART_N_PARITY_EN
    localparam int             FB         = 11;
    localparam logic [FB-1:0]  FIRST_BITS = 11'h6FE;
`else
    localparam int             FB         = 10;
    localparam logic [FB-1:0]  FIRST_BITS = 10'h2FE;
`endif
    localparam int          F       = FB * C;
    localparam logic [63:0] BUF_STD = 64'h55aaff001248137f;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_n_if u_if();

    uart_n #(.CLKS_PER_BIT(C)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_err   = 0;
    int low_cnt = 0;

    logic [7:0] exp_b [0:7] = '{8'h7f, 8'h13, 8'h48, 8'h12, 8'h00, 8'hff, 8'haa, 8'h55};

    // Counts falling-edge samples with idle low; read only while idle is steady high.
    always @(negedge clk) if (u_if.idle === 1'b0) low_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic sample_frame(output logic [FB-1:0] bits);
        for (int k = 0; k < FB; k++) begin
            bits[k] = u_if.tx;
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic do_xfer(input int n, input bit disturb);
        int            low0;
        logic [FB-1:0] bits;
        logic [7:0]    d;
        u_if.trig_in = 1'b1;
        low0 = low_cnt;
        @(negedge clk);
        check("lat_tx", u_if.tx, 1'b1);
        check("lat_idle", u_if.idle, 1'b1);
        u_if.trig_in = 1'b0;
        @(negedge clk);
        check("start_tx", u_if.tx, 1'b0);
        check("start_idle", u_if.idle, 1'b0);
        for (int j = 0; j < n; j++) begin
            if (disturb && j == 1) begin
                u_if.buffer  = 64'hdeadbeefcafef00d;
                u_if.num     = 4'd2;
                u_if.trig_in = 1'b1;
            end
            sample_frame(bits);
            if (disturb && j == 1) u_if.trig_in = 1'b0;
            d = bits[8:1];
            if (j == 0) check("frame0_bits", bits, FIRST_BITS);
            check($sformatf("byte%0d", j), d, exp_b[j]);
            check($sformatf("startbit%0d", j), bits[0], 1'b0);
            check($sformatf("stopbit%0d", j), bits[FB-1], 1'b1);
`ifdef UART_N_PARITY_EN
            check($sformatf("parity%0d", j), bits[9], ^d);
`endif
        end
        check("end_idle", u_if.idle, 1'b1);
        check("end_tx", u_if.tx, 1'b1);
        repeat (2) @(negedge clk);
        check("idle_low_cycles", low_cnt - low0, n * F);
    endtask

    initial begin
        int bad;
        int low0;
        u_if.buffer  = '0;
        u_if.num     = '0;
        u_if.trig_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", u_if.tx, 1'b1);
        check("rst_idle", u_if.idle, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tx", u_if.tx, 1'b1);
        check("post_rst_idle", u_if.idle, 1'b1);

        // Eight-byte transfer.
        u_if.buffer = BUF_STD;
        u_if.num    = 4'd8;
        do_xfer(8, 1'b0);

        // num=0 never starts.
        u_if.num     = 4'd0;
        u_if.trig_in = 1'b1;
        bad  = 0;
        low0 = low_cnt;
        repeat (20) begin
            @(negedge clk);
            if (u_if.tx !== 1'b1 || u_if.idle !== 1'b1) bad++;
        end
        u_if.trig_in = 1'b0;
        check("num0_bad_cycles", bad, 0);
        check("num0_low", low_cnt - low0, 0);

        // num above 8 is clamped.
        u_if.num = 4'd12;
        do_xfer(8, 1'b0);

        // Inputs disturbed while busy.
        u_if.num = 4'd8;
        do_xfer(8, 1'b1);
        bad = 0;
        repeat (2 * F) begin
            @(negedge clk);
            if (u_if.tx !== 1'b1 || u_if.idle !== 1'b1) bad++;
        end
        check("no_extra_frame", bad, 0);

        // Abort in the third data bit of byte 2.
        u_if.buffer  = BUF_STD;
        u_if.num     = 4'd8;
        u_if.trig_in = 1'b1;
        @(negedge clk);
        u_if.trig_in = 1'b0;
        @(negedge clk);
        repeat (2 * F + 3 * C + 1) @(negedge clk);
        check("abort_pre_tx", u_if.tx, 1'b0);
        check("abort_pre_idle", u_if.idle, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("abort_tx", u_if.tx, 1'b1);
        check("abort_idle", u_if.idle, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_abort_idle", u_if.idle, 1'b1);

        // Clean single frame from byte 0 after the abort.
        u_if.num = 4'd1;
        do_xfer(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_n.md
# uart_n

Multi-byte UART transmitter. On a trigger it latches up to eight bytes from a 64-bit buffer and serialises them back-to-back on one TX line as 8-N-1 frames, LSB first. It sits between message-building logic, which drives buffer, num and trig_in, and the board TX pin, and reports completion through idle.

## Interface
- CLKS_PER_BIT, default 217: clock cycles per bit; 217 gives 115200 baud at 25 MHz. Minimum legal value is 2.
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- buffer  input  64  payload; byte i is buffer[8i+7:8i]; byte 0 is sent first.
- num  input  4  number of bytes to send; values 9–15 are clamped to 8; value 0 sends nothing.
- trig_in  input  1  level-sensitive start request, sampled only while idle.
- idle  output  1  high when no transfer is in progress.
- TX  output  1  serial line, registered; high when idle (mark).

## Operation
- States:
  - IDLE: idle=1, TX=1.
  - START: TX=0.
  - DATA: 8 bits, LSB first.
  - PARITY: only when the parity feature is compiled in.
  - STOP: TX=1.
- IDLE -> START:
  - Taken on a rising edge with trig_in=1 and effective num≠0.
  - On that edge, latch buffer into a 64-bit shift register and load the byte counter with min(num,8).
  - With num=0, stay in IDLE.
- START -> DATA -> (PARITY) -> STOP: each bit lasts exactly CLKS_PER_BIT cycles, timed by an internal bit counter.
- STOP end:
  - Decrement the byte counter and shift the payload right by 8.
  - If bytes remain, go directly to START; there are no inter-byte gap cycles.
  - Otherwise go to IDLE.
- Triggers:
  - trig_in is ignored outside IDLE.
  - buffer and num changes after the latch edge have no effect on the current transfer.
  - If trig_in is held high, a new transfer starts one cycle after IDLE is re-entered. idle is therefore high for exactly 1 cycle between transfers.
- Reset, asserted at any time including mid-frame:
  - Immediately forces IDLE, TX=1, idle=1, and all counters and the shift register to 0.
  - Any partial frame is aborted.

## Timing
- Trigger edge = edge T. TX and idle are registered and change on edge T+1: TX falls and idle falls.
- Each bit occupies CLKS_PER_BIT cycles, measured from its first edge.
- Frame length F = 10·CLKS_PER_BIT, or 11·CLKS_PER_BIT with parity.
- The transfer occupies N·F cycles, where N = min(num,8). idle rises on edge T+1+N·F.
- TX never glitches: exactly one registered transition per bit boundary at most.

## Configuration
- Macro: UART_N_PARITY_EN.
- Defined:
  - Insert an even-parity bit between data bit 7 and the stop bit.
  - Parity bit = XOR of the 8 data bits.
  - Frame is 11 bits.
- Undefined: 8-N-1 frames of 10 bits. No parity state or logic is present.

## Test plan
- CLKS_PER_BIT=4; Reset pulse; buffer=64'h55aaff001248137f, num=8, trig_in=1:
  - Bytes go out in the order 7f,13,48,12,00,ff,aa,55.
  - First frame bits are 0,1,1,1,1,1,1,1,0,1.
  - idle is low for exactly 320 cycles.
  - A receiver model reconstructs all 8 bytes.
- num=0 with trig_in=1 for 20 cycles -> TX stays 1 and idle stays 1 throughout.
- num=4'd12, same buffer -> exactly 8 bytes sent; idle is low for 320 cycles.
- buffer and num changed, and trig_in pulsed, while busy -> the transfer is unaffected; no extra frame follows once trig_in is low.
- Reset asserted mid-way through the third data bit of byte 2 -> TX=1 and idle=1 without waiting for a clock edge; a new trigger then sends a clean frame from byte 0.
- UART_N_PARITY_EN defined, num=1, buffer[7:0]=8'h7f:
  - Bits are 0,1,1,1,1,1,1,1,0,1,1, where the parity bit is 1.
  - idle is low for 44 cycles.
